// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 stream accumulator.
//   fp32_t        : packed IEEE-754 single {s, e[7:0], m[22:0]}
//   accum_state_t : accumulator FSM states
package fp_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  localparam int          FP_BIAS     = 127;
  localparam logic [31:0] FP_POS_ZERO = 32'h0;
  localparam logic [30:0] FP_MAX_FIN  = 31'h7F7FFFFF;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} accum_state_t;

endpackage

// File: rtl/fp_stream_accum_if.sv
// Stream interface of the FP32 accumulator.
//   in_vld/in_rdy/in_fp/in_last : operand stream (master drives vld/fp/last)
//   out_vld/sum_fp/out_cnt      : frame result (slave drives)
interface fp_stream_accum_if #(
  parameter int CNT_W = 16
) ();
  logic             in_vld;
  logic             in_rdy;
  logic [31:0]      in_fp;
  logic             in_last;
  logic             out_vld;
  logic [31:0]      sum_fp;
  logic [CNT_W-1:0] out_cnt;

  modport master (output in_vld, in_fp, in_last,
                  input  in_rdy, out_vld, sum_fp, out_cnt);
  modport slave  (input  in_vld, in_fp, in_last,
                  output in_rdy, out_vld, sum_fp, out_cnt);
endinterface

// File: rtl/fp_lzc25.sv
// Combinational leading-zero counter over a 25-bit vector.
//   val : input vector, bit 24 is the most significant
//   lz  : number of leading zeros (25 when val is zero)
module fp_lzc25 (
  input  logic [24:0] val,
  output logic [4:0]  lz
);
  // Scan upward so the highest set bit is the last to write lz.
  always_comb begin
    lz = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (val[i]) lz = 5'(24 - i);
    end
  end
endmodule

// File: rtl/fp_stream_accum.sv
// Multi-cycle FP32 frame accumulator with truncating rounding.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous frame abort
//   bus      : fp_stream_accum_if.slave (operand stream in, frame sum out)
// Build option FP_ACCUM_NORM_LZC_EN: single-cycle normalisation using fp_lzc25;
// otherwise normalisation shifts left one bit per cycle. Results are identical.
//
// state | meaning
// IDLE  | waiting for an operand, in_rdy high
// ALIGN | order operands by exponent, shift smaller mantissa right
// ADD   | sign-magnitude add/subtract into 25-bit result
// NORM  | normalise, round by truncation, update acc on exit
// OUT   | publish acc/cnt, clear both for the next frame
module fp_stream_accum
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  fp_stream_accum_if.slave bus
);

  accum_state_t     state, state_nxt;
  fp32_t            op_q;
  logic             last_q;
  logic [31:0]      acc_q, sum_q;
  logic [CNT_W-1:0] cnt_q, out_cnt_q;
  logic             out_vld_q;
  logic             a_s, b_s, sat_q, sat_s_q, r_s;
  logic [7:0]       a_e;
  logic [23:0]      a_m, b_m;
  logic [24:0]      r_m, n_m, sum_m;
  logic signed [9:0] r_e, n_e;
  logic             n_done, sum_s, accept;
  logic [31:0]      norm_res;

  fp32_t       acc_f;
  logic [23:0] op_mag, acc_mag, big_mag, small_mag, small_sh;
  logic [7:0]  big_e, de;
  logic        op_sn, acc_sn, big_s, small_s;

  assign bus.in_rdy  = (state == IDLE) && !clr;
  assign accept      = bus.in_vld && bus.in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.sum_fp  = sum_q;
  assign bus.out_cnt = out_cnt_q;

  // Alignment: zero exponent means +0 (denormals flushed).
  always_comb begin
    acc_f   = acc_q;
    op_mag  = (op_q.e == 8'd0) ? 24'd0 : {1'b1, op_q.m};
    op_sn   = (op_q.e == 8'd0) ? 1'b0 : op_q.s;
    acc_mag = (acc_f.e == 8'd0) ? 24'd0 : {1'b1, acc_f.m};
    acc_sn  = (acc_f.e == 8'd0) ? 1'b0 : acc_f.s;
    if (op_q.e > acc_f.e) begin
      big_e = op_q.e;  big_mag = op_mag;  big_s = op_sn;
      de = op_q.e - acc_f.e;  small_mag = acc_mag;  small_s = acc_sn;
    end else begin
      big_e = acc_f.e; big_mag = acc_mag; big_s = acc_sn;
      de = acc_f.e - op_q.e;  small_mag = op_mag;  small_s = op_sn;
    end
    small_sh = (de >= 8'd25) ? 24'd0 : (small_mag >> de);
  end

  always_comb begin
    if (a_s == b_s) begin
      sum_m = {1'b0, a_m} + {1'b0, b_m};
      sum_s = a_s;
    end else if (a_m >= b_m) begin
      sum_m = {1'b0, a_m - b_m};
      sum_s = a_s;
    end else begin
      sum_m = {1'b0, b_m - a_m};
      sum_s = b_s;
    end
    if (sum_m == 25'd0) sum_s = 1'b0;
  end

`ifdef FP_ACCUM_NORM_LZC_EN
  logic [4:0] lz;
  fp_lzc25 u_lzc (.val(r_m), .lz(lz));

  always_comb begin
    n_m    = r_m;
    n_e    = r_e;
    n_done = 1'b1;
    if (r_m == 25'd0) begin
      n_m = r_m;
    end else if (r_m[24]) begin
      n_m = r_m >> 1;
      n_e = r_e + 10'sd1;
    end else if (!r_m[23]) begin
      // lz >= 2 here; bit 23 is the target position, hence lz-1.
      n_m = r_m << (lz - 5'd1);
      n_e = r_e - signed'({5'd0, lz - 5'd1});
    end
  end
`else
  // Finishing on the cycle the shifted value becomes normal keeps k shifts to k cycles.
  always_comb begin
    n_m    = r_m;
    n_e    = r_e;
    n_done = 1'b1;
    if (r_m == 25'd0) begin
      n_m = r_m;
    end else if (r_m[24]) begin
      n_m = r_m >> 1;
      n_e = r_e + 10'sd1;
    end else if (!r_m[23]) begin
      n_m    = r_m << 1;
      n_e    = r_e - 10'sd1;
      n_done = r_m[22];
    end
  end
`endif

  always_comb begin
    if (sat_q)                              norm_res = {sat_s_q, FP_MAX_FIN};
    else if (n_m == 25'd0 || n_e < 10'sd1)  norm_res = FP_POS_ZERO;
    else if (n_e >= 10'sd255)               norm_res = {r_s, FP_MAX_FIN};
    else                                    norm_res = {r_s, n_e[7:0], n_m[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (n_done) state_nxt = last_q ? OUT : IDLE;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    out_vld_q <= 1'b0;
    if (rst || clr) begin
      acc_q     <= FP_POS_ZERO;
      cnt_q     <= '0;
      sum_q     <= FP_POS_ZERO;
      out_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.in_fp;
          last_q <= bus.in_last;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        ALIGN: begin
          a_s     <= big_s;
          a_e     <= big_e;
          a_m     <= big_mag;
          b_s     <= small_s;
          b_m     <= small_sh;
          sat_q   <= (op_q.e == 8'hFF);
          sat_s_q <= op_q.s;
        end
        ADD: begin
          r_m <= sum_m;
          r_s <= sum_s;
          r_e <= signed'({2'b00, a_e});
        end
        NORM: begin
          r_m <= n_m;
          r_e <= n_e;
          if (n_done) acc_q <= norm_res;
        end
        OUT: begin
          sum_q     <= acc_q;
          out_cnt_q <= cnt_q;
          out_vld_q <= 1'b1;
          acc_q     <= FP_POS_ZERO;
          cnt_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
